regfile_wr_arbiter: RTL and testbench

//  Shares the single register-file write port between the main pipeline write-back and the multi-cycle

---
 rtl/regfile_wr_arbiter.sv | 97 +++++++++
 tb/tb_regfile_wr_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the regfile write port between WB and MDU, with an MDU busy scoreboard.
// Optional REGFILE_WR_BYPASS_EN adds forwarding of the in-flight write to the decode read ports.
module regfile_wr_arbiter #(
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_valid,
    input  logic [4:0]        p_rd,
    input  logic [DATA_W-1:0] p_data,
    output logic              p_ready,
    input  logic              m_valid,
    input  logic [4:0]        m_rd,
    input  logic [DATA_W-1:0] m_data,
    output logic              m_ready,
    input  logic              m_issue,
    input  logic [4:0]        m_issue_rd,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    output logic              busy_rs,
    output logic              busy_rt,
    output logic              regwrite,
    output logic [4:0]        rd,
    output logic [DATA_W-1:0] writedata,
    output logic              sb_err
`ifdef REGFILE_WR_BYPASS_EN
    ,
    output logic              rs_fwd,
    output logic [DATA_W-1:0] rs_fwd_data,
    output logic              rt_fwd,
    output logic [DATA_W-1:0] rt_fwd_data
`endif
);
    logic [3:0]        starve_q, starve_d;
    logic [31:0]       busy_q, busy_d;
    logic              sb_err_q, sb_err_d;
    logic              regwrite_q, regwrite_d;
    logic [4:0]        rd_q, rd_d;
    logic [DATA_W-1:0] writedata_q, writedata_d;
    logic              force_m, p_acc, m_acc;
    logic [31:0]       clr, set;

    // Arbitration, starvation counting, scoreboard and next write-port values
    always_comb begin
        force_m     = m_valid && (starve_q == 4'(STARVE_LIMIT));
        p_ready     = !force_m;
        m_ready     = m_valid && (force_m || !p_valid);
        p_acc       = p_valid && p_ready;
        m_acc       = m_valid && m_ready;
        starve_d    = (m_acc || !m_valid) ? 4'd0 :
                      (starve_q == 4'(STARVE_LIMIT)) ? starve_q : starve_q + 4'd1;
        regwrite_d  = p_acc ? (p_rd != 5'd0) : m_acc ? (m_rd != 5'd0) : 1'b0;
        rd_d        = p_acc ? p_rd : m_acc ? m_rd : rd_q;
        writedata_d = p_acc ? p_data : m_acc ? m_data : writedata_q;
        clr         = m_acc ? (32'd1 << m_rd) : 32'd0;
        set         = (m_issue && m_issue_rd != 5'd0) ? (32'd1 << m_issue_rd) : 32'd0;
        busy_d      = (busy_q & ~clr) | set;
        sb_err_d    = sb_err_q || ((set & busy_q & ~clr) != 32'd0);
        busy_rs     = (rs != 5'd0) && busy_q[rs];
        busy_rt     = (rt != 5'd0) && busy_q[rt];
    end

    // State registers; reset drops any in-flight write immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q    <= '0;
            busy_q      <= '0;
            sb_err_q    <= 1'b0;
            regwrite_q  <= 1'b0;
            rd_q        <= '0;
            writedata_q <= '0;
        end else begin
            starve_q    <= starve_d;
            busy_q      <= busy_d;
            sb_err_q    <= sb_err_d;
            regwrite_q  <= regwrite_d;
            rd_q        <= rd_d;
            writedata_q <= writedata_d;
        end
    end

    assign regwrite  = regwrite_q;
    assign rd        = rd_q;
    assign writedata = writedata_q;
    assign sb_err    = sb_err_q;

`ifdef REGFILE_WR_BYPASS_EN
    // Forward the write currently on the port, which the regfile read cannot yet return
    always_comb begin
        rs_fwd      = regwrite_q && (rd_q == rs) && (rs != 5'd0);
        rt_fwd      = regwrite_q && (rd_q == rt) && (rt != 5'd0);
        rs_fwd_data = writedata_q;
        rt_fwd_data = writedata_q;
    end
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed and random stimulus against a behavioural reference model.
module tb_regfile_wr_arbiter;
    localparam int DW = 32;
    localparam int LIM = 4;

    logic clk = 0, rst = 1;
    logic p_valid = 0, m_valid = 0, m_issue = 0;
    logic [4:0] p_rd = 0, m_rd = 0, m_issue_rd = 0, rs = 0, rt = 0;
    logic [DW-1:0] p_data = 0, m_data = 0;
    logic p_ready, m_ready, busy_rs, busy_rt, regwrite, sb_err;
    logic [4:0] rd;
    logic [DW-1:0] writedata;
`ifdef REGFILE_WR_BYPASS_EN
    logic rs_fwd, rt_fwd;
    logic [DW-1:0] rs_fwd_data, rt_fwd_data;
`endif

    int n_cmp = 0, n_err = 0;

    // Reference model state
    int refused;
    bit busy_m [32];
    bit err_m, we_m;
    logic [4:0] rd_m;
    logic [DW-1:0] wd_m;

    regfile_wr_arbiter #(.DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data), .p_ready(p_ready),
        .m_valid(m_valid), .m_rd(m_rd), .m_data(m_data), .m_ready(m_ready),
        .m_issue(m_issue), .m_issue_rd(m_issue_rd),
        .rs(rs), .rt(rt), .busy_rs(busy_rs), .busy_rt(busy_rt),
        .regwrite(regwrite), .rd(rd), .writedata(writedata), .sb_err(sb_err)
`ifdef REGFILE_WR_BYPASS_EN
        , .rs_fwd(rs_fwd), .rs_fwd_data(rs_fwd_data), .rt_fwd(rt_fwd), .rt_fwd_data(rt_fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        refused = 0;
        err_m = 0;
        we_m = 0;
        rd_m = 0;
        wd_m = 0;
        foreach (busy_m[i]) busy_m[i] = 0;
    endtask

    // One clock: check handshakes at negedge, advance the model, check the registered port after the edge
    task automatic step();
        bit frc, epr, emr, pa, ma;
        @(negedge clk);
        frc = m_valid && refused == LIM;
        epr = !frc;
        emr = m_valid && (frc || !p_valid);
        check("p_ready", p_ready, epr);
        check("m_ready", m_ready, emr);
        check("busy_rs", busy_rs, rs != 0 && busy_m[rs]);
        check("busy_rt", busy_rt, rt != 0 && busy_m[rt]);
`ifdef REGFILE_WR_BYPASS_EN
        check("rs_fwd", rs_fwd, we_m && rd_m == rs && rs != 0);
        check("rt_fwd", rt_fwd, we_m && rd_m == rt && rt != 0);
        if (we_m) check("rs_fwd_data", rs_fwd_data, wd_m);
`endif
        pa = p_valid && epr;
        ma = m_valid && emr;
        if (pa) begin we_m = p_rd != 0; rd_m = p_rd; wd_m = p_data; end
        else if (ma) begin we_m = m_rd != 0; rd_m = m_rd; wd_m = m_data; end
        else we_m = 0;
        refused = (ma || !m_valid) ? 0 : (refused < LIM ? refused + 1 : refused);
        if (ma) busy_m[m_rd] = 0;
        if (m_issue && m_issue_rd != 0) begin
            if (busy_m[m_issue_rd]) err_m = 1;
            busy_m[m_issue_rd] = 1;
        end
        @(posedge clk);
        #1;
        check("regwrite", regwrite, we_m);
        if (we_m) begin
            check("rd", rd, rd_m);
            check("writedata", writedata, wd_m);
        end
        check("sb_err", sb_err, err_m);
    endtask

    task automatic idle();
        p_valid = 0; m_valid = 0; m_issue = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("rst_regwrite", regwrite, 0);
        check("rst_sb_err", sb_err, 0);

        // Pipeline write with no MDU contention
        p_valid = 1; p_rd = 5; p_data = 32'hDEADBEEF; rs = 0; rt = 0;
        step();
        check("t2_rd", rd, 5);
        check("t2_wd", writedata, 32'hDEADBEEF);

        // MDU refused while pipeline keeps priority, then forced
        p_rd = 6; p_data = 32'h1111; m_valid = 1; m_rd = 7; m_data = 32'h7777;
        repeat (LIM + 1) step();
        check("t3_rd", rd, 7);
        check("t3_wd", writedata, 32'h7777);
        idle();
        step();

        // Scoreboard set, clear, and simultaneous set+clear
        m_issue = 1; m_issue_rd = 9; rs = 9; rt = 9;
        step();
        idle();
        step();
        check("t4_busy", busy_rs, 1);
        m_valid = 1; m_rd = 9; m_data = 32'h99;
        step();
        idle();
        check("t4_clear", busy_rs, 0);
        m_issue = 1;
        step();
        m_valid = 1;
        step();
        idle();
        check("t4_setwin", busy_rs, 1);
        check("t4_noerr", sb_err, 0);

        // Double issue without clear is a sticky error; rd==0 write suppressed
        m_issue = 1;
        step();
        idle();
        check("t5_err", sb_err, 1);
        p_valid = 1; p_rd = 0; p_data = 32'h55;
        step();
        check("t5_rd0", regwrite, 0);
        idle();
        step();
        check("t5_sticky", sb_err, 1);

        // Async reset mid-cycle with a write in flight and another pending
        p_valid = 1; p_rd = 12; p_data = 32'hABCD;
        step();
        #2 rst = 1;
        #1;
        check("ar_regwrite", regwrite, 0);
        check("ar_rd", rd, 0);
        check("ar_wd", writedata, 0);
        check("ar_err", sb_err, 0);
        check("ar_busy", busy_rs, 0);
        @(posedge clk);
        #1;
        check("ar_hold", regwrite, 0);
        idle();
        rst = 0;
        model_reset();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            p_valid = ($urandom_range(0, 9) < 6);
            m_valid = ($urandom_range(0, 9) < 5);
            m_issue = ($urandom_range(0, 9) < 2);
            p_rd = 5'($urandom_range(0, 7));
            m_rd = 5'($urandom_range(0, 7));
            m_issue_rd = 5'($urandom_range(0, 7));
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            p_data = $urandom;
            m_data = $urandom;
            if ($urandom_range(0, 499) == 0) begin
                rst = 1;
                @(posedge clk);
                #1 rst = 0;
                model_reset();
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
